// File: rtl/panda_dmem.sv
// Data-side memory responder: synchronous-read RAM plus optional MMIO window.
// Define PANDA_DMEM_MMIO_EN to build the cycle counter, SCRATCH and TOHOST/halt registers.
module panda_dmem #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_we_i,
    output logic [31:0] data_rdata_o,
    output logic        halt_o,
    output logic [31:0] tohost_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic          ram_sel;
    logic [31:0]   rd_next;
    logic          unused_addr;

    assign idx         = data_addr_i[AW+1:2];
    assign unused_addr = ^data_addr_i;

`ifdef PANDA_DMEM_MMIO_EN
    logic [63:0] cycle_q;
    logic [31:0] hi_latch_q;
    logic [31:0] scratch_q;
    logic [31:0] tohost_q;
    logic        halt_q;
    logic        mmio_sel;
    logic [1:0]  off;
    logic        wr_any;
    logic [31:0] mmio_rd;
    logic [31:0] tohost_mrg;
    logic [31:0] scratch_mrg;

    assign mmio_sel = data_addr_i[31];
    assign off      = data_addr_i[3:2];
    assign wr_any   = |data_we_i;
    assign ram_sel  = ~mmio_sel;
    assign halt_o   = halt_q;
    assign tohost_o = tohost_q;

    always_comb begin
        tohost_mrg  = tohost_q;
        scratch_mrg = scratch_q;
        for (int k = 0; k < 4; k++) begin
            if (data_we_i[k]) begin
                tohost_mrg[8*k +: 8]  = data_wdata_i[8*k +: 8];
                scratch_mrg[8*k +: 8] = data_wdata_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        mmio_rd = 32'h0;
        unique case (off)
            2'd0:    mmio_rd = cycle_q[31:0];
            2'd1:    mmio_rd = hi_latch_q;
            2'd2:    mmio_rd = tohost_q;
            default: mmio_rd = scratch_q;
        endcase
    end

    assign rd_next = mmio_sel ? mmio_rd : mem[idx];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_q    <= 64'h0;
            hi_latch_q <= 32'h0;
            scratch_q  <= 32'h0;
            tohost_q   <= 32'h0;
            halt_q     <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'h1;
            // snapshot upper half so a LO-then-HI pair reads one coherent value
            if (mmio_sel && off == 2'd0) begin
                hi_latch_q <= cycle_q[63:32];
            end
            if (mmio_sel && wr_any && off == 2'd3) begin
                scratch_q <= scratch_mrg;
            end
            if (mmio_sel && wr_any && off == 2'd2 && !halt_q) begin
                tohost_q <= tohost_mrg;
                if (tohost_mrg != 32'h0) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end
`else
    assign ram_sel  = 1'b1;
    assign rd_next  = mem[idx];
    assign halt_o   = 1'b0;
    assign tohost_o = 32'h0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_rdata_o <= 32'h0;
        end else begin
            data_rdata_o <= rd_next;
        end
    end

    // RAM is never cleared; reset only blocks stores
    always_ff @(posedge clk_i) begin
        if (rst_ni && ram_sel) begin
            for (int k = 0; k < 4; k++) begin
                if (data_we_i[k]) begin
                    mem[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_panda_dmem.sv
// Directed bench for panda_dmem: RAM, byte enables, read-first, wrap, reset,
// and the MMIO window when PANDA_DMEM_MMIO_EN is defined.
module tb_panda_dmem;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        halt;
    logic [31:0] tohost;

    int n_cmp = 0;
    int n_bad = 0;

    panda_dmem #(
        .DEPTH_WORDS(4096),
        .INIT_FILE("")
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .data_addr_i(addr),
        .data_wdata_i(wdata),
        .data_we_i(we),
        .data_rdata_o(rdata),
        .halt_o(halt),
        .tohost_o(tohost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        we    = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr  = 32'h0000_0010;
        wdata = 32'hFFFF_FFFF;
        we    = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0);
        end
        n_cmp++;
        if (halt !== 1'b0 || tohost !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_halt: got %b/%h want 0/0", halt, tohost);
        end
        @(negedge clk);
        we = 4'h0;
`ifdef PANDA_DMEM_MMIO_EN
        addr  = 32'h8000_0000;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL cycle_first: got %h want %h", rdata, 32'h0);
        end
        step(32'h8000_0000, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h1) begin
            n_bad++;
            $display("FAIL cycle_second: got %h want %h", rdata, 32'h1);
        end
`else
        rst_n = 1'b1;
`endif
    endtask

    task automatic test_read_latency();
        step(32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        step(32'h0000_0010, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL read_word4: got %h want %h", rdata, 32'hDEAD_BEEF);
        end
        step(32'h0000_0014, 32'h0, 4'h0);
        @(negedge clk);
        n_cmp++;
        if (rdata === 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL read_next_addr: got %h want not %h", rdata, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_byte_enable();
        step(32'h0000_0020, 32'h1122_3344, 4'hF);
        step(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
        step(32'h0000_0022, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h11BB_33DD) begin
            n_bad++;
            $display("FAIL byte_en: got %h want %h", rdata, 32'h11BB_33DD);
        end
        step(32'h0000_0020, 32'h9900_0000, 4'b1000);
        step(32'h0000_0020, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h99BB_33DD) begin
            n_bad++;
            $display("FAIL byte_en_top: got %h want %h", rdata, 32'h99BB_33DD);
        end
    endtask

    task automatic test_read_first();
        step(32'h0000_0040, 32'h1234_5678, 4'hF);
        step(32'h0000_0040, 32'h5555_5555, 4'hF);
        n_cmp++;
        if (rdata !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL read_first_old: got %h want %h", rdata, 32'h1234_5678);
        end
        step(32'h0000_0040, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h5555_5555) begin
            n_bad++;
            $display("FAIL read_first_new: got %h want %h", rdata, 32'h5555_5555);
        end
    endtask

    task automatic test_wrap();
        step(32'h0000_0000, 32'h0000_0000, 4'hF);
        step(32'h0000_4000, 32'h0000_0077, 4'hF);
        step(32'h0000_0000, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h0000_0077) begin
            n_bad++;
            $display("FAIL wrap: got %h want %h", rdata, 32'h0000_0077);
        end
        step(32'h0000_3FFC, 32'hCAFE_0001, 4'hF);
        step(32'h0000_7FFC, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'hCAFE_0001) begin
            n_bad++;
            $display("FAIL wrap_top: got %h want %h", rdata, 32'hCAFE_0001);
        end
    endtask

`ifdef PANDA_DMEM_MMIO_EN
    task automatic test_counter_atomic();
        @(negedge clk);
        dut.cycle_q = 64'h0000_0001_FFFF_FFFF;
        addr  = 32'h8000_0000;
        we    = 4'h0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (rdata !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL cycle_lo: got %h want %h", rdata, 32'hFFFF_FFFF);
        end
        step(32'h8000_0004, 32'hFFFF_FFFF, 4'hF);
        n_cmp++;
        if (rdata !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL cycle_hi: got %h want %h", rdata, 32'h0000_0001);
        end
    endtask

    task automatic test_scratch();
        step(32'h8000_000C, 32'hA1B2_C3D4, 4'hF);
        step(32'h8000_000C, 32'hFFFF_FFFF, 4'b0010);
        n_cmp++;
        if (rdata !== 32'hA1B2_C3D4) begin
            n_bad++;
            $display("FAIL scratch_old: got %h want %h", rdata, 32'hA1B2_C3D4);
        end
        step(32'hFFFF_FFFC, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'hA1B2_FFD4) begin
            n_bad++;
            $display("FAIL scratch_merge: got %h want %h", rdata, 32'hA1B2_FFD4);
        end
    endtask

    task automatic test_tohost();
        step(32'h8000_0008, 32'h0, 4'hF);
        n_cmp++;
        if (halt !== 1'b0 || tohost !== 32'h0) begin
            n_bad++;
            $display("FAIL tohost_zero: got %b/%h want 0/0", halt, tohost);
        end
        step(32'h8000_0008, 32'h0000_0001, 4'hF);
        n_cmp++;
        if (halt !== 1'b1 || tohost !== 32'h1) begin
            n_bad++;
            $display("FAIL tohost_set: got %b/%h want 1/1", halt, tohost);
        end
        step(32'h8000_0008, 32'h0000_0003, 4'hF);
        step(32'h8000_0008, 32'h0, 4'h0);
        n_cmp++;
        if (tohost !== 32'h1 || rdata !== 32'h1 || halt !== 1'b1) begin
            n_bad++;
            $display("FAIL tohost_locked: got %h/%h/%b want 1/1/1", tohost, rdata, halt);
        end
    endtask
`else
    task automatic test_bit31_ignored();
        step(32'h8000_0050, 32'h3C3C_A5A5, 4'hF);
        step(32'h0000_0050, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h3C3C_A5A5) begin
            n_bad++;
            $display("FAIL bit31_ram: got %h want %h", rdata, 32'h3C3C_A5A5);
        end
        n_cmp++;
        if (halt !== 1'b0 || tohost !== 32'h0) begin
            n_bad++;
            $display("FAIL mmio_tied: got %b/%h want 0/0", halt, tohost);
        end
    endtask
`endif

    task automatic test_midrun_reset();
        step(32'h0000_0060, 32'h0BAD_F00D, 4'hF);
        step(32'h0000_0060, 32'h0, 4'h0);
        @(negedge clk);
        addr  = 32'h0000_0060;
        wdata = 32'hFFFF_FFFF;
        we    = 4'hF;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rdata !== 32'h0 || halt !== 1'b0 || tohost !== 32'h0) begin
            n_bad++;
            $display("FAIL async_clear: got %h/%b/%h want 0/0/0", rdata, halt, tohost);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        we    = 4'h0;
        rst_n = 1'b1;
        step(32'h0000_0060, 32'h0, 4'h0);
        n_cmp++;
        if (rdata !== 32'h0BAD_F00D) begin
            n_bad++;
            $display("FAIL store_blocked: got %h want %h", rdata, 32'h0BAD_F00D);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        we    = 4'h0;
        test_reset();
        test_read_latency();
        test_byte_enable();
        test_read_first();
        test_wrap();
`ifdef PANDA_DMEM_MMIO_EN
        test_counter_atomic();
        test_scratch();
        test_tohost();
`else
        test_bit31_ignored();
`endif
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
